mmio_responder: RTL
===================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder for the single-cycle CPU data bus.
- Answers CPU loads and stores to the KEY, SW, HEX and LEDR address windows, so those addresses are kept out of data memory.
- Owns the board I/O: synchronises and debounces the inputs, holds the output registers, and keeps sticky ready/overrun status bits so software can poll for input changes.

Parameters:
- DBITS, 32, bus data/address width.
- ADDR_HEX, 32'hF0000000, HEX output register address.
- ADDR_LEDR, 32'hF0000004, LEDR output register address.
- ADDR_KEY, 32'hF0000010, KDATA address (read-only).
- ADDR_SW, 32'hF0000014, SDATA address (read-only).
- ADDR_KCTRL, 32'hF0000110, key status/control address.
- ADDR_SCTRL, 32'hF0000114, switch status/control address.
- DEBOUNCE_CYCLES, 10, cycles a synchronised SW value must stay stable before SDATA accepts it (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- addr  in  DBITS  CPU data address (the ALU result).
- wr_en  in  1  store strobe.
- rd_en  in  1  load strobe; only used for read side effects.
- wdata  in  DBITS  store data.
- rdata  out  DBITS  load data, combinational.
- sel  out  1  high when addr matches any mapped register; steers the CPU's load mux and suppresses the data-memory write.
- KEY  in  4  raw keys, active-low.
- SW  in  10  raw switches.
- HEX  out  16  HEX display value (four nibbles).
- LEDR  out  10  LED value.

Behaviour:
Decode and bus timing
- Decode is a full 32-bit equality match against the six addresses.
- Any other address: sel=0, rdata=0, writes ignored.
- rdata is a combinational function of addr and the current register state; no read latency.
- Writes and read side effects take effect at the next rising edge of clk.

Reset
- Reset applies on any edge where reset=1, including in mid-operation. It overrides all bus activity in that cycle.
- HEX=0, LEDR=0, KDATA=0, SDATA=0, all ready/overrun bits=0.
- Synchroniser flops and the debounce counter clear to 0.

Input path
- KEY is inverted (pressed=1) and passed through 2 flops; SW also passes through 2 flops.
- Latency from a KEY change to a KDATA change: 3 edges.

HEX and LEDR
- RW registers.
- A write stores wdata[15:0] into HEX or wdata[9:0] into LEDR.
- A read returns the register value zero-extended to 32 bits.

KDATA
- Each cycle the synchronised key value is compared with KDATA. On any difference:
  - KDATA takes the new value.
  - KCTRL.ready (bit0) is set.
  - If ready was already 1 and no KDATA read happens this cycle, KCTRL.overrun (bit2) is also set.
- A read of KDATA with rd_en=1 clears ready.
- A change in the same cycle as a KDATA read leaves ready=1 and overrun unchanged (set wins over clear).

SDATA
- Debounce counter:
  - Reloads to 0 whenever the synchronised SW differs from the previous synchronised SW.
  - Otherwise increments, saturating at DEBOUNCE_CYCLES.
- When the counter equals DEBOUNCE_CYCLES and the synchronised value differs from SDATA:
  - SDATA takes the value and SCTRL.ready is set.
  - Overrun follows the same rules as KCTRL.
- Stability also counts across a reset release.

KCTRL / SCTRL layout
- bit0 ready, read-only.
- bit2 overrun.
- All other bits read 0.
- A write with wdata[2]=0 clears overrun. A write with wdata[2]=1 leaves it unchanged.
- A write never changes ready.
- If overrun is set and cleared in the same cycle, set wins.

Other rules
- rd_en without address decode has no effect.
- wr_en to KDATA or SDATA is ignored.
- Simultaneous rd_en and wr_en: both act; the read side effect applies only to KDATA/SDATA addresses.

Optional Feature:
- Macro MMIO_TIMER_EN adds a timer.
- Defined:
  - Adds TCNT at 32'hF0000020 (RW) and TLIM at 32'hF0000024 (RW, reset 0) and TCTRL at 32'hF0000120 (same ready/overrun layout).
  - TCNT increments once per clock.
  - When TLIM!=0 and TCNT==TLIM-1, TCNT wraps to 0 and TCTRL.ready is set; overrun is set if ready was already 1.
  - Reading TCTRL with rd_en=1 clears ready.
  - A write to TCNT overrides the increment in that cycle.
  - TLIM=0 means TCNT wraps naturally at 2^32 and never sets ready.
- Undefined: those three addresses are unmapped (sel=0, rdata=0).

Test Plan:
1. Reset, then write 0x0000ABCD to 0xF0000000 and 0x3FF to 0xF0000004.
   Expect HEX=0xABCD, LEDR=0x3FF, and a read-back returning the same values.
2. Drive KEY=4'b1110 from 4'b1111.
   Expect KDATA=0x1 after 3 edges and KCTRL=0x1. A read of KDATA with rd_en=1 then gives KCTRL=0x0.
3. Two key changes with no KDATA read in between.
   Expect KCTRL=0x5. Writing 0 to 0xF0000110 gives KCTRL=0x1. A KDATA read in the same cycle as a new change leaves KCTRL=0x1.
4. SW toggles 0x001/0x000 every 3 cycles for 20 cycles, then holds 0x2AA.
   Expect SDATA to stay 0 during the toggling. SDATA becomes 0x2AA exactly DEBOUNCE_CYCLES+3 edges after the hold starts, and SCTRL.ready=1.
5. Address 0xF0000008: expect sel=0, rdata=0, and a write changes nothing. Assert reset with ready=1 and HEX nonzero: expect all outputs and status to be 0 on the next edge.
6. (MMIO_TIMER_EN) TLIM=5: expect TCTRL.ready every 5 cycles and TCNT sequence 0,1,2,3,4,0. Leave ready unread for a second wrap: expect TCTRL=0x5.

Source files
------------

// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//
// Memory-mapped I/O responder on the single-cycle CPU data bus. Decodes the
// HEX, LEDR, KEY, SW and status/control windows, owns the board I/O registers,
// synchronises and debounces the raw inputs, and keeps sticky ready/overrun
// status bits so software can poll for input changes.
//
// Optional build macro: MMIO_TIMER_EN
//   When defined, adds a free-running timer (TCNT, TLIM, TCTRL). When it is
//   undefined, those three addresses are unmapped.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous reset, active-high; overrides bus activity
//   addr   in   CPU data address (ALU result)
//   wr_en  in   store strobe
//   rd_en  in   load strobe, used only for read side effects
//   wdata  in   store data
//   rdata  out  load data, combinational in addr and register state
//   sel    out  high when addr hits a mapped register
//   KEY    in   raw keys, active-low
//   SW     in   raw switches
//   HEX    out  HEX display value (four nibbles)
//   LEDR   out  LED value
// -----------------------------------------------------------------------------
module mmio_responder #(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114,
  parameter int                DEBOUNCE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [15:0]      HEX,
  output logic [9:0]       LEDR
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

`ifdef MMIO_TIMER_EN
  localparam logic [DBITS-1:0] ADDR_TCNT  = 32'hF0000020;
  localparam logic [DBITS-1:0] ADDR_TLIM  = 32'hF0000024;
  localparam logic [DBITS-1:0] ADDR_TCTRL = 32'hF0000120;
`endif

  // ---------------------------------------------------------------------------
  // Address decode (full-width equality)
  // ---------------------------------------------------------------------------
  logic hit_hex, hit_ledr, hit_key, hit_sw, hit_kctrl, hit_sctrl;

  assign hit_hex   = (addr == ADDR_HEX);
  assign hit_ledr  = (addr == ADDR_LEDR);
  assign hit_key   = (addr == ADDR_KEY);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sctrl = (addr == ADDR_SCTRL);

`ifdef MMIO_TIMER_EN
  logic hit_tcnt, hit_tlim, hit_tctrl;
  assign hit_tcnt  = (addr == ADDR_TCNT);
  assign hit_tlim  = (addr == ADDR_TLIM);
  assign hit_tctrl = (addr == ADDR_TCTRL);
  assign sel = hit_hex | hit_ledr | hit_key | hit_sw | hit_kctrl | hit_sctrl |
               hit_tcnt | hit_tlim | hit_tctrl;
`else
  assign sel = hit_hex | hit_ledr | hit_key | hit_sw | hit_kctrl | hit_sctrl;
`endif

  // Upper store-data bits are only consumed by the optional timer.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[DBITS-1:16]};

  // ---------------------------------------------------------------------------
  // Input synchronisers. Keys are inverted so a pressed key reads as 1.
  // ---------------------------------------------------------------------------
  logic [3:0] key_pressed;
  logic [3:0] key_s1_reg, key_s2_reg;
  logic [9:0] sw_s1_reg, sw_s2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_inv
      assign key_pressed[gi] = ~KEY[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_reg <= '0;
      key_s2_reg <= '0;
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
    end else begin
      key_s1_reg <= key_pressed;
      key_s2_reg <= key_s1_reg;
      sw_s1_reg  <= SW;
      sw_s2_reg  <= sw_s1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [15:0]   hex_reg,   hex_next;
  logic [9:0]    ledr_reg,  ledr_next;
  logic [3:0]    kdata_reg, kdata_next;
  logic          krdy_reg,  krdy_next;
  logic          kovr_reg,  kovr_next;
  logic [9:0]    sdata_reg, sdata_next;
  logic          srdy_reg,  srdy_next;
  logic          sovr_reg,  sovr_next;
  logic [CW-1:0] dcnt_reg,  dcnt_next;

  logic key_rd, sw_rd, key_chg, sw_chg;

  assign key_rd  = rd_en & hit_key;
  assign sw_rd   = rd_en & hit_sw;
  assign key_chg = (key_s2_reg != kdata_reg);
  // SDATA only accepts a value once the debounce counter has saturated.
  assign sw_chg  = (dcnt_reg == DB_MAX) && (sw_s2_reg != sdata_reg);

`ifdef MMIO_TIMER_EN
  logic [DBITS-1:0] tcnt_reg, tcnt_next;
  logic [DBITS-1:0] tlim_reg, tlim_next;
  logic             trdy_reg, trdy_next;
  logic             tovr_reg, tovr_next;
  logic             tmr_rd, tmr_wrap;

  assign tmr_rd   = rd_en & hit_tctrl;
  // A TCNT store overrides the increment, so it also suppresses the wrap event.
  assign tmr_wrap = (tlim_reg != '0) && (tcnt_reg == tlim_reg - 1'b1) &&
                    !(wr_en && hit_tcnt);
`endif

  always_comb begin
    hex_next   = hex_reg;
    ledr_next  = ledr_reg;
    kdata_next = kdata_reg;
    krdy_next  = krdy_reg;
    kovr_next  = kovr_reg;
    sdata_next = sdata_reg;
    srdy_next  = srdy_reg;
    sovr_next  = sovr_reg;
    dcnt_next  = dcnt_reg;

    if (wr_en && hit_hex)  hex_next  = wdata[15:0];
    if (wr_en && hit_ledr) ledr_next = wdata[9:0];

    // Key status: clears are applied first so that a same-cycle set wins.
    if (key_rd) krdy_next = 1'b0;
    if (wr_en && hit_kctrl && !wdata[2]) kovr_next = 1'b0;
    if (key_chg) begin
      kdata_next = key_s2_reg;
      krdy_next  = 1'b1;
      if (krdy_reg && !key_rd) kovr_next = 1'b1;
    end

    // Debounce: sw_s1 is the value sw_s2 takes next, so a mismatch means the
    // synchronised value is about to change and stability restarts from 0.
    if (sw_s1_reg != sw_s2_reg) begin
      dcnt_next = '0;
    end else if (dcnt_reg != DB_MAX) begin
      dcnt_next = dcnt_reg + 1'b1;
    end

    if (sw_rd) srdy_next = 1'b0;
    if (wr_en && hit_sctrl && !wdata[2]) sovr_next = 1'b0;
    if (sw_chg) begin
      sdata_next = sw_s2_reg;
      srdy_next  = 1'b1;
      if (srdy_reg && !sw_rd) sovr_next = 1'b1;
    end
  end

`ifdef MMIO_TIMER_EN
  always_comb begin
    tcnt_next = tcnt_reg + 1'b1;
    tlim_next = tlim_reg;
    trdy_next = trdy_reg;
    tovr_next = tovr_reg;

    if (wr_en && hit_tlim) tlim_next = wdata;

    if (wr_en && hit_tcnt) begin
      tcnt_next = wdata;
    end else if (tmr_wrap) begin
      tcnt_next = '0;
    end

    if (tmr_rd) trdy_next = 1'b0;
    if (wr_en && hit_tctrl && !wdata[2]) tovr_next = 1'b0;
    if (tmr_wrap) begin
      trdy_next = 1'b1;
      if (trdy_reg && !tmr_rd) tovr_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_reg <= '0;
      tlim_reg <= '0;
      trdy_reg <= 1'b0;
      tovr_reg <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      tlim_reg <= tlim_next;
      trdy_reg <= trdy_next;
      tovr_reg <= tovr_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_reg   <= '0;
      ledr_reg  <= '0;
      kdata_reg <= '0;
      krdy_reg  <= 1'b0;
      kovr_reg  <= 1'b0;
      sdata_reg <= '0;
      srdy_reg  <= 1'b0;
      sovr_reg  <= 1'b0;
      dcnt_reg  <= '0;
    end else begin
      hex_reg   <= hex_next;
      ledr_reg  <= ledr_next;
      kdata_reg <= kdata_next;
      krdy_reg  <= krdy_next;
      kovr_reg  <= kovr_next;
      sdata_reg <= sdata_next;
      srdy_reg  <= srdy_next;
      sovr_reg  <= sovr_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (zero-extended; status words carry ready in bit0, overrun in bit2)
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (hit_hex)   rdata = {{(DBITS-16){1'b0}}, hex_reg};
    if (hit_ledr)  rdata = {{(DBITS-10){1'b0}}, ledr_reg};
    if (hit_key)   rdata = {{(DBITS-4){1'b0}}, kdata_reg};
    if (hit_sw)    rdata = {{(DBITS-10){1'b0}}, sdata_reg};
    if (hit_kctrl) rdata = {{(DBITS-3){1'b0}}, kovr_reg, 1'b0, krdy_reg};
    if (hit_sctrl) rdata = {{(DBITS-3){1'b0}}, sovr_reg, 1'b0, srdy_reg};
`ifdef MMIO_TIMER_EN
    if (hit_tcnt)  rdata = tcnt_reg;
    if (hit_tlim)  rdata = tlim_reg;
    if (hit_tctrl) rdata = {{(DBITS-3){1'b0}}, tovr_reg, 1'b0, trdy_reg};
`endif
  end

  assign HEX  = hex_reg;
  assign LEDR = ledr_reg;

endmodule
